// File: rtl/route_alloc_ctrl_pkg.sv
// route_alloc_ctrl_pkg
// Shared constants and types for the route allocator slice.
//   RA_CHANNEL_NUM / RA_CAPACITOR_NUM : default channel and slot counts
//   RA_CH_W / RA_CAP_W                : derived index widths
//   ra_state_e                        : allocator FSM state encoding
package route_alloc_ctrl_pkg;

  localparam int RA_CHANNEL_NUM   = 8;
  localparam int RA_CAPACITOR_NUM = 16;
  localparam int RA_CH_W          = $clog2(RA_CHANNEL_NUM);
  localparam int RA_CAP_W         = $clog2(RA_CAPACITOR_NUM);

  typedef enum logic [1:0] {
    RA_IDLE  = 2'd0,
    RA_SCAN  = 2'd1,
    RA_ISSUE = 2'd2,
    RA_DONE  = 2'd3
  } ra_state_e;

endpackage

// File: rtl/route_alloc_ctrl_if.sv
// route_alloc_ctrl_if
// Bundles the control, request and binding handshake signals of the route
// allocator.
//   slave  : the allocator side (takes start/abort/requests/map_ready,
//            drives the binding, status and result signals)
//   master : the controller/consumer side, the mirror image of slave
interface route_alloc_ctrl_if
  import route_alloc_ctrl_pkg::*;
#(
  parameter int CHANNEL_NUM   = RA_CHANNEL_NUM,
  parameter int CAPACITOR_NUM = RA_CAPACITOR_NUM,
  parameter int CH_W          = $clog2(CHANNEL_NUM),
  parameter int CAP_W         = $clog2(CAPACITOR_NUM)
);

  logic                     start;
  logic                     abort;
  logic [CHANNEL_NUM-1:0]   chan_req;
  logic [CAPACITOR_NUM-1:0] cap_avail;
  logic                     map_valid;
  logic                     map_ready;
  logic [CH_W-1:0]          map_chan;
  logic [CAP_W-1:0]         map_cap;
  logic                     busy;
  logic                     done;
  logic [CAPACITOR_NUM-1:0] cap_used;
  logic [CHANNEL_NUM-1:0]   unserved;
  logic                     overflow;

  modport slave (
    input  start, abort, chan_req, cap_avail, map_ready,
    output map_valid, map_chan, map_cap, busy, done, cap_used, unserved,
           overflow
  );

  modport master (
    output start, abort, chan_req, cap_avail, map_ready,
    input  map_valid, map_chan, map_cap, busy, done, cap_used, unserved,
           overflow
  );

endinterface

// File: rtl/route_alloc_ctrl_lsb_first_enc.sv
// lsb_first_enc
// Priority encoder that reports the index of the lowest set bit.
//   vec   : input bit vector (WIDTH bits)
//   idx   : index of the lowest set bit, 0 when none is set
//   found : 1 when any bit of vec is set
module lsb_first_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Walk from the top bit down so the last hit written is the lowest index,
  // which gives the lowest-index-wins priority the distributor fills in.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/route_alloc_ctrl.sv
// route_alloc_ctrl
// Binds requesting input channels to free sampling-capacitor slots, one
// (channel, capacitor) pair per valid/ready handshake, lowest pending channel
// to lowest free slot.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : route_alloc_ctrl_if.slave
//           start/abort      pass control (start honoured only in IDLE)
//           chan_req/cap_avail  captured on an accepted start
//           map_valid/map_ready/map_chan/map_cap  binding handshake
//           busy/done        status (done pulses on normal completion)
//           cap_used         slots bound in the current or last pass
//           unserved/overflow  requests left unbound by the last pass
module route_alloc_ctrl
  import route_alloc_ctrl_pkg::*;
#(
  parameter int CHANNEL_NUM   = RA_CHANNEL_NUM,
  parameter int CAPACITOR_NUM = RA_CAPACITOR_NUM,
  parameter int CH_W          = $clog2(CHANNEL_NUM),
  parameter int CAP_W         = $clog2(CAPACITOR_NUM)
) (
  input logic              clk,
  input logic              rst_n,
  route_alloc_ctrl_if.slave bus
);

  ra_state_e                state_q, state_d;
  logic [CHANNEL_NUM-1:0]   req_q, req_d;
  logic [CAPACITOR_NUM-1:0] avail_q, avail_d;
  logic                     map_valid_q, map_valid_d;
  logic [CH_W-1:0]          map_chan_q, map_chan_d;
  logic [CAP_W-1:0]         map_cap_q, map_cap_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [CAPACITOR_NUM-1:0] cap_used_q, cap_used_d;
  logic [CHANNEL_NUM-1:0]   unserved_q, unserved_d;
  logic                     overflow_q, overflow_d;

  logic [CH_W-1:0]          req_idx;
  logic [CAP_W-1:0]         avail_idx;
  logic                     req_found;
  logic                     avail_found;

  lsb_first_enc #(
    .WIDTH (CHANNEL_NUM),
    .IDX_W (CH_W)
  ) u_chan_enc (
    .vec   (req_q),
    .idx   (req_idx),
    .found (req_found)
  );

  lsb_first_enc #(
    .WIDTH (CAPACITOR_NUM),
    .IDX_W (CAP_W)
  ) u_cap_enc (
    .vec   (avail_q),
    .idx   (avail_idx),
    .found (avail_found)
  );

  // State register. Reset drops any binding in flight and returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RA_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Abort overrides everything, including a start in IDLE
  // and a handshake completing in ISSUE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RA_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = RA_SCAN;
        end
      end
      RA_SCAN: begin
        if (bus.abort) begin
          state_d = RA_IDLE;
        end else if (!req_found || !avail_found) begin
          state_d = RA_DONE;
        end else begin
          state_d = RA_ISSUE;
        end
      end
      RA_ISSUE: begin
        if (bus.abort) begin
          state_d = RA_IDLE;
        end else if (bus.map_ready) begin
          state_d = RA_SCAN;
        end
      end
      RA_DONE: begin
        state_d = RA_IDLE;
      end
      default: begin
        state_d = RA_IDLE;
      end
    endcase
  end

  // Output/datapath logic. Every output is computed one cycle ahead from the
  // next state so that all ports come straight from flops.
  always_comb begin
    req_d       = req_q;
    avail_d     = avail_q;
    map_valid_d = map_valid_q;
    map_chan_d  = map_chan_q;
    map_cap_d   = map_cap_q;
    cap_used_d  = cap_used_q;
    unserved_d  = unserved_q;
    overflow_d  = overflow_q;
    busy_d      = (state_d != RA_IDLE);
    done_d      = (state_d == RA_DONE);

    if (state_q == RA_IDLE && state_d == RA_SCAN) begin
      req_d      = bus.chan_req;
      avail_d    = bus.cap_avail;
      cap_used_d = '0;
    end

    if (state_q == RA_SCAN && state_d == RA_ISSUE) begin
      map_chan_d  = req_idx;
      map_cap_d   = avail_idx;
      map_valid_d = 1'b1;
    end

    // Leftover requests are latched only on a normal finish, so an aborted
    // pass leaves the previous result visible.
    if (state_q == RA_SCAN && state_d == RA_DONE) begin
      unserved_d = req_q;
      overflow_d = |req_q;
    end

    if (state_q == RA_ISSUE && state_d == RA_SCAN) begin
      req_d       = req_q & ~(CHANNEL_NUM'(1) << map_chan_q);
      avail_d     = avail_q & ~(CAPACITOR_NUM'(1) << map_cap_q);
      cap_used_d  = cap_used_q | (CAPACITOR_NUM'(1) << map_cap_q);
      map_valid_d = 1'b0;
    end

    if (state_d == RA_IDLE) begin
      map_valid_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      avail_q     <= '0;
      map_valid_q <= 1'b0;
      map_chan_q  <= '0;
      map_cap_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cap_used_q  <= '0;
      unserved_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      req_q       <= req_d;
      avail_q     <= avail_d;
      map_valid_q <= map_valid_d;
      map_chan_q  <= map_chan_d;
      map_cap_q   <= map_cap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cap_used_q  <= cap_used_d;
      unserved_q  <= unserved_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.map_valid = map_valid_q;
  assign bus.map_chan  = map_chan_q;
  assign bus.map_cap   = map_cap_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cap_used  = cap_used_q;
  assign bus.unserved  = unserved_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_route_alloc_ctrl.sv
// tb_route_alloc_ctrl
// Self-checking bench for route_alloc_ctrl with 8 channels and 16 slots.
// A table of passes is applied in a loop; expected bindings go into a
// scoreboard queue when a pass is started and are popped as the DUT hands
// them out. Abort and mid-pass reset are exercised by hand-written sequences.
module tb_route_alloc_ctrl;

  localparam int NCH  = 8;
  localparam int NCAP = 16;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  route_alloc_ctrl_if #(.CHANNEL_NUM(NCH), .CAPACITOR_NUM(NCAP)) ra_if ();

  route_alloc_ctrl #(.CHANNEL_NUM(NCH), .CAPACITOR_NUM(NCAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ra_if)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]  req;
    logic [NCAP-1:0] avail;
    int              stall_lo;
    int              stall_hi;
    logic [NCAP-1:0] cap_used;
    logic [NCH-1:0]  unserved;
    logic            ovf;
    int              done_cyc;
  } vec_t;

  typedef struct {
    int chan;
    int cap;
    int cyc;
  } bind_t;

  vec_t  tbl [6];
  bind_t sb [$];

  // Single comparison; every failure prints one FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int lowest_bit(input logic [31:0] x);
    for (int i = 0; i < 32; i++) begin
      if (x[i]) return i;
    end
    return -1;
  endfunction

  // Reference model of the bindings a pass should produce, including the
  // cycle (relative to the start edge) in which each handshake completes.
  task automatic push_expected(input vec_t v);
    logic [31:0] r;
    logic [31:0] a;
    int          t;
    int          h;
    bind_t       b;
    r = 32'(v.req);
    a = 32'(v.avail);
    t = 1;
    while (r != 0 && a != 0) begin
      b.chan = lowest_bit(r);
      b.cap  = lowest_bit(a);
      h = t + 1;
      while (h >= v.stall_lo && h <= v.stall_hi) h++;
      b.cyc = h;
      sb.push_back(b);
      r[b.chan] = 1'b0;
      a[b.cap]  = 1'b0;
      t = h + 1;
    end
  endtask

  // Called just after a falling edge: load the pass inputs and pulse start
  // across the next rising edge (cycle 0).
  task automatic applyStimulus(input vec_t v);
    push_expected(v);
    ra_if.chan_req  = v.req;
    ra_if.cap_avail = v.avail;
    ra_if.map_ready = 1'b1;
    ra_if.start     = 1'b1;
    @(posedge clk);
    #1;
    ra_if.start = 1'b0;
  endtask

  // Sample each cycle on the falling edge, drive map_ready for that cycle,
  // and compare bindings and the final result against the expectations.
  task automatic run_pass(input string tag, input vec_t v);
    bit    got_done;
    bind_t f;
    got_done = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      ra_if.map_ready = (c >= v.stall_lo && c <= v.stall_hi) ? 1'b0 : 1'b1;
      if (c == 1) checkOutput({tag, "_busy_rise"}, 32'(ra_if.busy), 32'd1);
      if (ra_if.map_valid) begin
        if (sb.size() == 0) begin
          checkOutput({tag, "_spurious_valid"}, 32'(ra_if.map_valid), 32'd0);
        end else begin
          f = sb[0];
          checkOutput({tag, "_map_chan"}, 32'(ra_if.map_chan), 32'(f.chan));
          checkOutput({tag, "_map_cap"}, 32'(ra_if.map_cap), 32'(f.cap));
          if (ra_if.map_ready) begin
            checkOutput({tag, "_hs_cycle"}, 32'(c), 32'(f.cyc));
            void'(sb.pop_front());
          end
        end
      end
      if (ra_if.done) begin
        got_done = 1'b1;
        checkOutput({tag, "_done_cycle"}, 32'(c), 32'(v.done_cyc));
        checkOutput({tag, "_cap_used"}, 32'(ra_if.cap_used), 32'(v.cap_used));
        checkOutput({tag, "_unserved"}, 32'(ra_if.unserved), 32'(v.unserved));
        checkOutput({tag, "_overflow"}, 32'(ra_if.overflow), 32'(v.ovf));
        checkOutput({tag, "_missing_bindings"}, 32'(sb.size()), 32'd0);
        break;
      end
    end
    if (!got_done) begin
      checkOutput({tag, "_done_timeout"}, 32'(got_done), 32'd1);
    end
    @(negedge clk);
    ra_if.map_ready = 1'b1;
    checkOutput({tag, "_busy_fall"}, 32'(ra_if.busy), 32'd0);
    checkOutput({tag, "_done_pulse_width"}, 32'(ra_if.done), 32'd0);
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_map_valid"}, 32'(ra_if.map_valid), 32'd0);
    checkOutput({tag, "_map_chan"}, 32'(ra_if.map_chan), 32'd0);
    checkOutput({tag, "_map_cap"}, 32'(ra_if.map_cap), 32'd0);
    checkOutput({tag, "_busy"}, 32'(ra_if.busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(ra_if.done), 32'd0);
    checkOutput({tag, "_cap_used"}, 32'(ra_if.cap_used), 32'd0);
    checkOutput({tag, "_unserved"}, 32'(ra_if.unserved), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(ra_if.overflow), 32'd0);
  endtask

  initial begin
    bit saw_done;

    //             req           avail     lo  hi   cap_used  unserved ovf done
    tbl[0] = '{8'b0010_0101, 16'h00F0, 0, -1, 16'h0070, 8'h00, 1'b0, 8};
    tbl[1] = '{8'b0010_0101, 16'h00F0, 2,  4, 16'h0070, 8'h00, 1'b0, 11};
    tbl[2] = '{8'h00,        16'h00F0, 0, -1, 16'h0000, 8'h00, 1'b0, 2};
    tbl[3] = '{8'h81,        16'h0000, 0, -1, 16'h0000, 8'h81, 1'b1, 2};
    tbl[4] = '{8'h80,        16'h8000, 0, -1, 16'h8000, 8'h00, 1'b0, 4};
    tbl[5] = '{8'hFF,        16'h0003, 0, -1, 16'h0003, 8'hFC, 1'b1, 6};

    rst_n           = 1'b0;
    ra_if.start     = 1'b0;
    ra_if.abort     = 1'b0;
    ra_if.chan_req  = '0;
    ra_if.cap_avail = '0;
    ra_if.map_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      run_pass($sformatf("pass%0d", i), tbl[i]);
    end

    // Abort in cycle 4 of the normal pass, with a start pulse in cycle 3
    // that must be ignored because the block is busy.
    saw_done = 1'b0;
    ra_if.chan_req  = 8'b0010_0101;
    ra_if.cap_avail = 16'h00F0;
    ra_if.map_ready = 1'b1;
    ra_if.start     = 1'b1;
    @(posedge clk);
    #1;
    ra_if.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ra_if.done) saw_done = 1'b1;
      if (c == 2) begin
        checkOutput("abort_bind0_valid", 32'(ra_if.map_valid), 32'd1);
        checkOutput("abort_bind0_chan", 32'(ra_if.map_chan), 32'd0);
        checkOutput("abort_bind0_cap", 32'(ra_if.map_cap), 32'd4);
      end
      if (c == 3) begin
        ra_if.start    = 1'b1;
        ra_if.chan_req = 8'hFF;
      end
      if (c == 4) begin
        ra_if.start = 1'b0;
        checkOutput("abort_bind1_valid", 32'(ra_if.map_valid), 32'd1);
        checkOutput("abort_bind1_chan", 32'(ra_if.map_chan), 32'd2);
        checkOutput("abort_bind1_cap", 32'(ra_if.map_cap), 32'd5);
        ra_if.abort = 1'b1;
      end
      if (c == 5) begin
        ra_if.abort = 1'b0;
        checkOutput("abort_map_valid", 32'(ra_if.map_valid), 32'd0);
        checkOutput("abort_cap_used", 32'(ra_if.cap_used), 32'h0010);
        checkOutput("abort_unserved_kept", 32'(ra_if.unserved), 32'hFC);
        checkOutput("abort_overflow_kept", 32'(ra_if.overflow), 32'd1);
      end
      if (c >= 5) checkOutput($sformatf("abort_busy_c%0d", c),
                              32'(ra_if.busy), 32'd0);
    end
    checkOutput("abort_no_done", 32'(saw_done), 32'd0);

    // Reset in the middle of a pass while a binding is on the port, then a
    // start in the very first cycle after reset release.
    ra_if.chan_req  = 8'hFF;
    ra_if.cap_avail = 16'h0003;
    ra_if.map_ready = 1'b1;
    ra_if.start     = 1'b1;
    @(posedge clk);
    #1;
    ra_if.start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midrst_pre_valid", 32'(ra_if.map_valid), 32'd1);
    checkOutput("midrst_pre_cap_used", 32'(ra_if.cap_used), 32'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(tbl[0]);
    run_pass("postrst", tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
